mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Multi-cycle main-memory responder: the serving end of the CPU/cache memory interface. The CPU fetch/data path and the cache fill logic act as initiators.
- Accepts single-word reads, single-word writes and 8-word line-fill bursts over a valid/ready request channel.
- Returns read data over a response channel after a fixed, pipelined latency.
- Replaces the single-cycle memory model for the multi-cycle memory phase.

Parameters:
- LATENCY, 4, cycles from request acceptance to the first response word (legal range 1..8).
- DEPTH_LOG2, 15, log2 of storage depth in 16-bit words.
- BURST_LEN, 8, words per line-fill burst (power of two).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_wr  input  1  1 = write, 0 = read.
- req_burst  input  1  read is a line-fill burst; ignored when req_wr=1.
- req_addr  input  16  byte address; bit 0 ignored.
- req_wdata  input  16  write data.
- resp_valid  output  1  response word valid this cycle.
- resp_data  output  16  read data.
- resp_last  output  1  final word of a response (always 1 for single reads).
- busy  output  1  burst issuing or any response in flight.

Behaviour:
- Reset values (cycle after rst=1):
  - req_ready=1, resp_valid=0, resp_data=0, resp_last=0, busy=0.
  - Pipeline valids cleared; state IDLE.
  - Storage contents are preserved (not cleared).
- Word index = req_addr[DEPTH_LOG2:1]. Higher address bits are ignored, so addresses wrap modulo the depth.
- Accept: a request is accepted when req_valid && req_ready on a rising edge. At most one request is accepted per cycle.
- Write:
  - Storage is updated at the accepting edge.
  - No response is generated.
  - A read accepted on the next cycle or later sees the new value.
- Single read:
  - Storage is sampled at the accepting edge (cycle N).
  - resp_valid=1, resp_last=1 and the data appear in cycle N+LATENCY.
- Reads and writes are pipelined back-to-back. A read at N followed by a write to the same address at N+1 returns the old data.
- Burst read: FSM states IDLE and BURST.
  - Accepting a burst at N: base = req_addr with the low log2(BURST_LEN)+1 bits cleared (16-byte aligned); go to BURST.
  - Word k (0..BURST_LEN-1) is sampled at cycle N+k from base+2k and responded at N+k+LATENCY.
  - resp_last=1 only on word BURST_LEN-1.
  - req_ready=0 from N+1 through N+BURST_LEN-1; return to IDLE after the last word issues.
  - req_ready=1 at N+BURST_LEN.
  - A new request may be accepted at N+BURST_LEN while burst responses are still draining.
- Response ordering is strictly in acceptance order. Responses are never stalled: the initiator must always accept resp_valid.
- busy=1 while in BURST or while any pipeline stage is valid.
- A write in the cycle after a burst completes issuing is legal and does not affect already-sampled burst words.
- Reset mid-burst or with reads in flight:
  - All pending responses are dropped; resp_valid=0 the next cycle.
  - FSM goes to IDLE; no partial responses emerge after reset.
- req_wdata and req_burst are don't-care for reads and writes respectively.
- Back-pressure exists only via req_ready during bursts. There is no full or empty condition beyond the pipeline depth, which equals LATENCY.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, BURST}.
  - WORD_BYTES=2 and LINE_BYTES constants.
  - Address-to-index helper.
- Sub-module latency_pipe:
  - LATENCY-deep shift register of {valid, last, data}.
  - Synchronous reset clears the valid bits only.
- Top level: storage array, FSM, burst counter, accept logic.

Test Plan:
- Write 0xBEEF to addr 0x0010 at cycle 2, read 0x0010 at cycle 3 -> resp_valid=1, resp_data=0xBEEF, resp_last=1 at cycle 7 (LATENCY=4).
- Read 0x0020 (old value 0x1111) at N, write 0x2222 to 0x0020 at N+1 -> response at N+4 = 0x1111; a read at N+2 returns 0x2222 at N+6.
- Preload 0x0040..0x004E with 0xA0..0xA7, burst read at addr 0x0046 -> req_ready=0 for 7 cycles; 8 responses 0xA0..0xA7 on consecutive cycles starting N+4; resp_last only on 0xA7.
- Single reads every cycle to 0x0000, 0x0002, 0x0004 -> three consecutive responses in the same order, no gaps, busy high throughout.
- Burst accepted at N, rst=1 at N+3 -> from N+4: resp_valid=0, req_ready=1, busy=0; no further responses; storage still holds preloaded values.
- Address 0x0000 vs 0x0000+2^(DEPTH_LOG2+1) (DEPTH_LOG2=4: 0x0020) -> both read the same word (wrap check).

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Summary  : Shared types, constants and address helper for the memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int WORD_BYTES    = 2;
  localparam int DEF_BURST_LEN = 8;
  localparam int LINE_BYTES    = WORD_BYTES * DEF_BURST_LEN;

  // Byte address to word index; higher bits dropped so addresses wrap on the depth.
  function automatic logic [15:0] addr_to_index(input logic [15:0] addr, input int depth_log2);
    logic [15:0] mask;
    mask = (16'd1 << depth_log2) - 16'd1;
    return (addr >> 1) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/latency_pipe.sv
// ============================================================================
// Module   : latency_pipe
// Summary  : Fixed-depth shift register carrying {valid, last, data} responses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module latency_pipe #(
  parameter int LATENCY = 4,
  parameter int WIDTH   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic             i_last,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic             o_last,
  output logic [WIDTH-1:0] o_data,
  output logic             o_any_valid
);

  logic [LATENCY-1:0] r_valid;
  logic [LATENCY-1:0] r_last;
  logic [WIDTH-1:0]   r_data [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_valid;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  // Payload carries no reset; the output gating below hides stale contents.
  always_ff @(posedge clk) begin
    r_last[0] <= i_last;
    r_data[0] <= i_data;
    for (int i = 1; i < LATENCY; i++) begin
      r_last[i] <= r_last[i-1];
      r_data[i] <= r_data[i-1];
    end
  end

  assign o_valid     = r_valid[LATENCY-1];
  assign o_last      = r_valid[LATENCY-1] & r_last[LATENCY-1];
  assign o_data      = r_valid[LATENCY-1] ? r_data[LATENCY-1] : '0;
  assign o_any_valid = |r_valid;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Summary  : Multi-cycle main-memory responder with single and line-fill reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 15,
  parameter int BURST_LEN  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_burst,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_last,
  output logic        busy
);

  localparam int c_DEPTH  = 1 << DEPTH_LOG2;
  localparam int c_BEAT_W = $clog2(BURST_LEN);
  localparam logic [DEPTH_LOG2-1:0] c_LINE_MASK = DEPTH_LOG2'(BURST_LEN - 1);

  logic [15:0]           r_mem [c_DEPTH];
  state_t                r_state, w_state_nxt;
  logic [c_BEAT_W-1:0]   r_beat, w_beat_nxt;
  logic [DEPTH_LOG2-1:0] r_base, w_base_nxt;
  logic [DEPTH_LOG2-1:0] w_req_idx, w_issue_idx;
  logic [15:0]           w_idx16, w_rd_data;
  logic                  w_accept, w_wr_en, w_issue_valid, w_issue_last;
  logic                  w_pipe_any, w_unused;

  assign w_idx16   = addr_to_index(req_addr, DEPTH_LOG2);
  assign w_req_idx = w_idx16[DEPTH_LOG2-1:0];
  assign w_unused  = ^w_idx16[15:DEPTH_LOG2];

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid && req_ready && !rst;
  assign w_wr_en   = w_accept && req_wr;

  always_comb begin
    w_state_nxt   = r_state;
    w_beat_nxt    = r_beat;
    w_base_nxt    = r_base;
    w_issue_valid = 1'b0;
    w_issue_last  = 1'b0;
    w_issue_idx   = w_req_idx;
    case (r_state)
      IDLE: begin
        if (w_accept && !req_wr) begin
          w_issue_valid = 1'b1;
          if (req_burst) begin
            // Word 0 issues on the accepting edge; BURST walks the remaining words.
            w_issue_idx = w_req_idx & ~c_LINE_MASK;
            w_base_nxt  = w_req_idx & ~c_LINE_MASK;
            w_beat_nxt  = c_BEAT_W'(1);
            w_state_nxt = BURST;
          end else begin
            w_issue_last = 1'b1;
          end
        end
      end
      BURST: begin
        w_issue_valid = 1'b1;
        w_issue_idx   = r_base | DEPTH_LOG2'(r_beat);
        w_issue_last  = (r_beat == c_BEAT_W'(BURST_LEN - 1));
        w_beat_nxt    = r_beat + c_BEAT_W'(1);
        if (w_issue_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_base  <= w_base_nxt;
    end
  end

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_req_idx] <= req_wdata;
    end
  end

  assign w_rd_data = r_mem[w_issue_idx];

  latency_pipe #(
    .LATENCY (LATENCY),
    .WIDTH   (16)
  ) u_pipe (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (w_issue_valid),
    .i_last      (w_issue_last),
    .i_data      (w_rd_data),
    .o_valid     (resp_valid),
    .o_last      (resp_last),
    .o_data      (resp_data),
    .o_any_valid (w_pipe_any)
  );

  assign busy = (r_state == BURST) || w_pipe_any;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Summary  : Directed self-checking bench for mem_responder (LATENCY=4, DEPTH_LOG2=7).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr, req_burst;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_last, busy;
  logic [15:0] resp_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .LATENCY    (4),
    .DEPTH_LOG2 (7),
    .BURST_LEN  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_burst  (req_burst),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_last  (resp_last),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wr, input logic bu,
                       input logic [15:0] a, input logic [15:0] d);
    req_valid = v;
    req_wr    = wr;
    req_burst = bu;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
    drive(1'b1, 1'b1, 1'b0, a, d);
    tick();
    idle();
  endtask

  // Single read at cycle N, response checked at N+4.
  task automatic rd_expect(input string tag, input logic [15:0] a, input logic [15:0] exp);
    drive(1'b1, 1'b0, 1'b0, a, 16'h0000);
    tick();
    idle();
    tick();
    tick();
    tick();
    check_eq({tag, "_valid"}, 16'(resp_valid), 16'h1);
    check_eq({tag, "_data"}, resp_data, exp);
    check_eq({tag, "_last"}, 16'(resp_last), 16'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    check_eq("rst_ready", 16'(req_ready), 16'h1);
    check_eq("rst_valid", 16'(resp_valid), 16'h0);
    check_eq("rst_data", resp_data, 16'h0000);
    check_eq("rst_last", 16'(resp_last), 16'h0);
    check_eq("rst_busy", 16'(busy), 16'h0);
    rst = 1'b0;

    // Write then read-after-write with exact latency
    wr_word(16'h0010, 16'hBEEF);
    drive(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    check_eq("t1_ready", 16'(req_ready), 16'h1);
    tick();
    idle();
    tick();
    tick();
    check_eq("t1_early", 16'(resp_valid), 16'h0);
    tick();
    check_eq("t1_valid", 16'(resp_valid), 16'h1);
    check_eq("t1_data", resp_data, 16'hBEEF);
    check_eq("t1_last", 16'(resp_last), 16'h1);

    // Read / write / read to one address, pipelined back-to-back
    wr_word(16'h0020, 16'h1111);
    drive(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    tick();
    drive(1'b1, 1'b1, 1'b0, 16'h0020, 16'h2222);
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
    tick();
    idle();
    check_eq("t2_busy", 16'(busy), 16'h1);
    tick();
    check_eq("t2_old_valid", 16'(resp_valid), 16'h1);
    check_eq("t2_old_data", resp_data, 16'h1111);
    tick();
    check_eq("t2_gap", 16'(resp_valid), 16'h0);
    tick();
    check_eq("t2_new_valid", 16'(resp_valid), 16'h1);
    check_eq("t2_new_data", resp_data, 16'h2222);
    check_eq("t2_new_last", 16'(resp_last), 16'h1);
    tick();

    // Line-fill burst from an unaligned address; a held write must wait for ready
    for (int k = 0; k < 8; k++) begin
      wr_word(16'(16'h0040 + 2 * k), 16'(16'h00A0 + k));
    end
    drive(1'b1, 1'b0, 1'b1, 16'h0046, 16'h0000);
    check_eq("t3_accept_ready", 16'(req_ready), 16'h1);
    tick();
    for (int c = 1; c <= 12; c++) begin
      if (c == 1) drive(1'b1, 1'b1, 1'b0, 16'h004E, 16'hDEAD);
      if (c <= 7) begin
        check_eq($sformatf("t3_ready_c%0d", c), 16'(req_ready), 16'h0);
        check_eq($sformatf("t3_busy_c%0d", c), 16'(busy), 16'h1);
      end
      if (c == 8) check_eq("t3_ready_back", 16'(req_ready), 16'h1);
      if (c == 9) idle();
      if (c >= 4 && c <= 11) begin
        check_eq($sformatf("t3_valid_w%0d", c - 4), 16'(resp_valid), 16'h1);
        check_eq($sformatf("t3_data_w%0d", c - 4), resp_data, 16'(16'h00A0 + c - 4));
        check_eq($sformatf("t3_last_w%0d", c - 4), 16'(resp_last), 16'(c == 11));
      end
      if (c == 12) begin
        check_eq("t3_drained_valid", 16'(resp_valid), 16'h0);
        check_eq("t3_drained_busy", 16'(busy), 16'h0);
      end
      tick();
    end
    rd_expect("t3_held_write", 16'h004E, 16'hDEAD);

    // Three single reads on consecutive cycles
    wr_word(16'h0000, 16'h0C00);
    wr_word(16'h0002, 16'h0C02);
    wr_word(16'h0004, 16'h0C04);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    check_eq("t4_busy_c1", 16'(busy), 16'h1);
    drive(1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000);
    tick();
    check_eq("t4_busy_c2", 16'(busy), 16'h1);
    drive(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000);
    tick();
    idle();
    for (int c = 3; c <= 7; c++) begin
      check_eq($sformatf("t4_busy_c%0d", c), 16'(busy), 16'(c <= 6));
      if (c >= 4 && c <= 6) begin
        check_eq($sformatf("t4_valid_c%0d", c), 16'(resp_valid), 16'h1);
        check_eq($sformatf("t4_data_c%0d", c), resp_data, 16'(16'h0C00 + 2 * (c - 4)));
        check_eq($sformatf("t4_last_c%0d", c), 16'(resp_last), 16'h1);
      end
      if (c == 7) check_eq("t4_end_valid", 16'(resp_valid), 16'h0);
      tick();
    end

    // Reset in the middle of a burst drops everything in flight
    drive(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000);
    tick();
    idle();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_eq("t5_valid", 16'(resp_valid), 16'h0);
    check_eq("t5_ready", 16'(req_ready), 16'h1);
    check_eq("t5_busy", 16'(busy), 16'h0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("t5_quiet_%0d", i), 16'(resp_valid), 16'h0);
    end
    rd_expect("t5_mem_kept", 16'h0042, 16'h00A1);

    // Address wrap: 0x0100 aliases 0x0000 with 128 words
    wr_word(16'h0100, 16'h5A5A);
    rd_expect("t6_wrap_lo", 16'h0000, 16'h5A5A);
    rd_expect("t6_wrap_hi", 16'h0102, 16'h0C02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
